// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronises the pins, deframes 11-bit frames and folds E0/F0 prefixes
// into one 32-bit keyCode per key event; key_valid/frame_err are single-cycle pulses.
module ps2_scancode_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 65000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [31:0] keyCode,
  output logic        key_valid,
  output logic        frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
  logic                   clk_prev_q;
  logic [2:0]             cnt_q, cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_q, par_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   ext_q, ext_d, rel_q, rel_d;
  logic [31:0]            key_q, key_d;
  logic                   kv_q, kv_d, ferr_q, ferr_d;

  logic ps2_clk_s, ps2_dat_s, fall, tmo_hit, byte_ok, bad_frame;

  assign ps2_clk_s = clk_sync_q[SYNC_STAGES-1];
  assign ps2_dat_s = dat_sync_q[SYNC_STAGES-1];
  assign fall      = clk_prev_q & ~ps2_clk_s;
  assign tmo_hit   = (state_q != IDLE) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  assign keyCode   = key_q;
  assign key_valid = kv_q;
  assign frame_err = ferr_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      ext_q      <= 1'b0;
      rel_q      <= 1'b0;
      key_q      <= '0;
      kv_q       <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q <= ps2_clk_s;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      ext_q      <= ext_d;
      rel_q      <= rel_d;
      key_q      <= key_d;
      kv_q       <= kv_d;
      ferr_q     <= ferr_d;
    end
  end

  // Frame FSM; an expiring timeout takes priority over an edge in the same cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tmo_d     = '0;
    byte_ok   = 1'b0;
    bad_frame = 1'b0;
    if (tmo_hit) begin
      state_d   = IDLE;
      bad_frame = 1'b1;
    end else begin
      if (state_q != IDLE && !fall) tmo_d = tmo_q + 1'b1;
      if (fall) begin
        case (state_q)
          IDLE: begin
            if (!ps2_dat_s) begin
              state_d = DATA;
              cnt_d   = '0;
            end
          end
          DATA: begin
            shift_d = {ps2_dat_s, shift_q[7:1]};
            if (cnt_q == 3'd7) state_d = PARITY;
            else               cnt_d   = cnt_q + 3'd1;
          end
          PARITY: begin
            par_d   = ps2_dat_s;
            state_d = STOP;
          end
          STOP: begin
            state_d = IDLE;
            if (ps2_dat_s && (^{shift_q, par_q})) byte_ok   = 1'b1;
            else                                  bad_frame = 1'b1;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // Sequence assembler: prefixes set sticky flags consumed by the next real code.
  always_comb begin
    ext_d  = ext_q;
    rel_d  = rel_q;
    key_d  = key_q;
    kv_d   = 1'b0;
    ferr_d = bad_frame;
    if (bad_frame) begin
      ext_d = 1'b0;
      rel_d = 1'b0;
    end else if (byte_ok) begin
      case (shift_q)
        8'hE0: ext_d = 1'b1;
        8'hF0: rel_d = 1'b1;
        8'hE1: begin
        end
        8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF: begin
          ext_d = 1'b0;
          rel_d = 1'b0;
        end
        default: begin
          key_d = {(rel_q ? 16'h00F0 : 16'h0000), (ext_q ? 8'hE0 : 8'h00), shift_q};
          kv_d  = 1'b1;
          ext_d = 1'b0;
          rel_d = 1'b0;
        end
      endcase
    end
  end

endmodule
